// File: rtl/one_hot_decoder_8_if.sv
// Bundle between the upstream 8:3 encoder, the one-hot decoder and its consumer.
// No latency: wires only.
// Backpressure: in_ready is the decoder's accept signal for in_valid/in_code.
interface one_hot_decoder_8_if;
   logic [2:0] in_code;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out;
   logic       out_valid;
   logic [2:0] out_index;
   logic       busy;

   // Upstream/consumer side: drives the code, observes the decode
   modport master (
      output in_code, in_valid,
      input  in_ready, out, out_valid, out_index, busy
   );

   // Decoder side
   modport slave (
      input  in_code, in_valid,
      output in_ready, out, out_valid, out_index, busy
   );
endinterface

// File: rtl/one_hot_decoder_8.sv
// Registered 3:8 one-hot decoder; each accepted code is held HOLD_CYCLES cycles, then one zero cycle.
// Latency 1: out is visible the cycle after the accepting edge; one code per HOLD_CYCLES+2 cycles.
// Backpressure: in_ready only in IDLE; optional seen/seen_clr ports under ONE_HOT_DECODER_8_SEEN_EN.
module one_hot_decoder_8 #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef ONE_HOT_DECODER_8_SEEN_EN
   output logic [7:0]              seen,
   input  logic                    seen_clr,
`endif
   one_hot_decoder_8_if.slave      bus
);

   // The hold counter is 8 bits, so only 1..255 is representable
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("one_hot_decoder_8: HOLD_CYCLES must be in 1..255");
   end

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

   state_t     state_q, state_d;
   logic [7:0] out_q, out_d;
   logic       vld_q, vld_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ready;
   logic       accept;
   logic [7:0] code_hot;

   // Ready is forced low during reset even though the state already reads IDLE
   assign ready    = (state_q == IDLE) && rst_n;
   assign accept   = ready && bus.in_valid;
   assign code_hot = 8'(1) << bus.in_code;

   // Next-state and output-register logic for the IDLE/DRIVE/GAP sequence
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               out_d   = code_hot;
               idx_d   = bus.in_code;
               vld_d   = 1'b1;
               cnt_d   = HOLD_LOAD;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == 8'd0) begin
               out_d   = 8'h00;
               vld_d   = 1'b0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            out_d   = 8'h00;
            vld_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the output immediately, discarding any in-flight code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= 8'h00;
         vld_q   <= 1'b0;
         idx_q   <= 3'b000;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;
   assign bus.out_index = idx_q;
   assign bus.busy      = (state_q != IDLE);

`ifdef ONE_HOT_DECODER_8_SEEN_EN
   logic [7:0] seen_q, seen_d;
   logic [7:0] seen_set;

   assign seen_set = accept ? code_hot : 8'h00;

   // Sticky record of accepted codes; a clear in the same cycle as an accept keeps only the new bit
   always_comb begin
      seen_d = seen_clr ? seen_set : (seen_q | seen_set);
   end

   // Seen register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= 8'h00;
      end else begin
         seen_q <= seen_d;
      end
   end

   assign seen = seen_q;
`endif

endmodule

// File: doc/one_hot_decoder_8.md
ONE_HOT_DECODER_8 -- requirements
Module: one_hot_decoder_8

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 4, number of cycles each accepted code is driven on the one-hot output (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_code  input  3  binary index from upstream 8:3 priority encoder.
REQ-005 SHALL have port: in_valid  input  1  in_code is valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port: out  output  8  registered one-hot decode of the accepted code.
REQ-008 SHALL have port: out_valid  output  1  out currently carries a decoded code.
REQ-009 SHALL have port: out_index  output  3  registered copy of the code currently driven.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, DRIVE, GAP.
REQ-012 SHALL drive in_ready=1 only in IDLE; 0 in DRIVE and GAP.
REQ-013 SHALL accept a code only on a rising edge where in_valid=1 and in_ready=1; in_code SHALL be ignored at all other times.
REQ-014 On accept: SHALL load out_index=in_code, set out[in_code]=1 with all other bits 0, load hold counter with HOLD_CYCLES-1, move to DRIVE; out is visible the cycle after the accepting edge (latency 1).
REQ-015 In DRIVE: SHALL hold out, out_index and out_valid=1 stable; SHALL decrement the 8-bit hold counter each cycle; on counter=0, SHALL clear out to 8'h00, clear out_valid, move to GAP.
REQ-016 In GAP: SHALL keep out=8'h00, out_valid=0 for exactly one cycle, then move to IDLE.
REQ-017 out SHALL never have more than one bit set; consecutive codes SHALL always be separated by at least one all-zero cycle.
REQ-018 Throughput SHALL be one code per HOLD_CYCLES+2 cycles under continuous in_valid.
REQ-019 HOLD_CYCLES=1 SHALL give exactly one DRIVE cycle; HOLD_CYCLES values 0 or above 255 are illegal and SHALL be flagged by an elaboration-time error.
REQ-020 in_valid held high during DRIVE/GAP SHALL not be accepted until IDLE; upstream SHALL keep code stable until accepted.
REQ-021 out_index SHALL retain its last value after DRIVE ends (only meaningful when out_valid=1).

Reset
REQ-022 On rst_n=0, asynchronously and immediately: state=IDLE, out=8'h00, out_valid=0, out_index=3'b000, counter=0, busy=0; in_ready SHALL be 0 while rst_n=0.
REQ-023 Reset asserted mid-DRIVE SHALL drop out to 8'h00 without waiting for a clock edge; the in-flight code is discarded.
REQ-024 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-025 Macro ONE_HOT_DECODER_8_SEEN_EN, when defined, SHALL add ports seen (output, 8) and seen_clr (input, 1).
REQ-026 With the macro: seen[i] SHALL set on the edge accepting code i and remain set until seen_clr=1 at a rising edge or reset; a simultaneous accept and seen_clr SHALL leave only the new code's bit set.
REQ-027 Without the macro: the seen/seen_clr ports and their register SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-028 Reset: rst_n=0 mid-DRIVE with out=8'h20 -> out=8'h00, out_valid=0, busy=0 before next edge.
REQ-029 Single code: HOLD_CYCLES=4, in_code=3'd5 accepted at edge 0 -> out=8'h20, out_index=5 for cycles 1-4, out=8'h00 at cycle 5 (GAP), in_ready=1 at cycle 6.
REQ-030 Back-to-back: in_valid held high, codes 7 then 0 -> 8'h80 for 4 cycles, one 8'h00 cycle, one IDLE cycle, then 8'h01; second accept at edge 6.
REQ-031 Minimum hold: HOLD_CYCLES=1, code 3 -> out=8'h08 for exactly one cycle, then 8'h00.
REQ-032 Ignored input: in_code toggles 1..6 during DRIVE with in_valid=1 -> out stays at accepted value; one-hot check on every cycle.
REQ-033 SEEN_EN build: accept codes 2 and 6, then seen_clr with simultaneous accept of code 1 -> seen=8'h44 then 8'h02.
